// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
//   Shared types and constants for the adder entry sequencer.
//   - state_t     : sequencer states; the encoding is visible on state_o.
//   - BLANK_*     : per-state digit blank masks, [3]=A [2]=B [1]=cout [0]=sum,
//                   where 1 switches the digit off.
//   - blank_for() : maps a state to its blank mask.
// -----------------------------------------------------------------------------
package adder_seq_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_CALC = 2'd2,
        S_SUM  = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_A    = 4'b0111;  // only A visible
    localparam logic [3:0] BLANK_B    = 4'b0011;  // A and B visible
    localparam logic [3:0] BLANK_CALC = 4'b0011;  // result not captured yet
    localparam logic [3:0] BLANK_SUM  = 4'b0000;  // everything visible

    function automatic logic [3:0] blank_for(input state_t s);
        logic [3:0] mask;
        case (s)
            S_A:     mask = BLANK_A;
            S_B:     mask = BLANK_B;
            S_CALC:  mask = BLANK_CALC;
            S_SUM:   mask = BLANK_SUM;
            default: mask = BLANK_A;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Debounces one raw active-low key that is asynchronous to clk.
//   The key is brought in through a 2-flop synchroniser and inverted to
//   active-high. The accepted level flips only after DEBOUNCE_CYCLES
//   consecutive cycles in which the synchronised level differs from it.
//   press_pulse is a registered one-cycle pulse on an accepted
//   released->pressed transition. Releases do not pulse.
//
//   Ports
//     clk          in   system clock
//     reset        in   asynchronous active-high reset
//     raw_n        in   raw key, low = pressed
//     level        out  accepted level, 1 = pressed
//     press_pulse  out  one-cycle pulse when a press is accepted
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic press_pulse
);

    // The counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             pressed_s;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Synchroniser. It resets to the released (high) level, so a key held
    // through reset is seen as a new press once reset is released.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], raw_n};
        end
    end

    assign pressed_s = ~sync_q[1];

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (pressed_s == level_q) begin
            // Agreement with the accepted level restarts the run.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = pressed_s;
            cnt_d   = '0;
            pulse_d = pressed_s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign level       = level_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/adder_entry_sequencer.sv
// -----------------------------------------------------------------------------
// adder_entry_sequencer
//   Sequences operand entry for an external WIDTH-bit adder. The operator
//   sets A on the Hex switches and presses ENTER, then sets B and presses
//   ENTER. The result is captured one cycle later and shown until the next
//   ENTER. CLEAR returns to operand A entry from any state.
//
//   Ports
//     clk        in   system clock
//     reset      in   asynchronous active-high reset (release synchronised here)
//     Hex        in   operand switches
//     cin_sw     in   carry-in switch
//     button     in   raw active-low keys, [0]=ENTER [1]=CLEAR
//     add_a      out  operand A to adder
//     add_b      out  operand B to adder
//     add_cin    out  carry-in to adder
//     add_sum    in   adder sum
//     add_cout   in   adder carry-out
//     disp_a     out  A digit nibble (live Hex while entering A)
//     disp_b     out  B digit nibble (live Hex while entering B)
//     disp_sum   out  sum digit nibble
//     disp_cout  out  carry digit value
//     blank      out  per-digit blank, [3]=A [2]=B [1]=cout [0]=sum
//     state_o    out  current state for LEDs/debug
// -----------------------------------------------------------------------------
module adder_entry_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Hex,
    input  logic             cin_sw,
    input  logic [1:0]       button,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] disp_a,
    output logic [WIDTH-1:0] disp_b,
    output logic [WIDTH-1:0] disp_sum,
    output logic             disp_cout,
    output logic [3:0]       blank,
    output logic [1:0]       state_o
);

    // ---------------------------------------------------------------- reset
    // Assertion reaches every flop at once; release is delayed two edges so
    // all flops leave reset in the same cycle.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    // -------------------------------------------------------------- buttons
    logic enter_pulse, clear_pulse;
    logic enter_level, clear_level;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk         (clk),
        .reset       (rst_int),
        .raw_n       (button[0]),
        .level       (enter_level),
        .press_pulse (enter_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk         (clk),
        .reset       (rst_int),
        .raw_n       (button[1]),
        .level       (clear_level),
        .press_pulse (clear_pulse)
    );

    // Accepted levels are only for probing; the sequencer acts on pulses.
    logic unused_levels;
    assign unused_levels = enter_level ^ clear_level;

    // ------------------------------------------------------ state register
    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------- next state
    // CLEAR is tested first so it wins over a same-cycle ENTER.
    // S_CALC ignores ENTER and always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        if (clear_pulse) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A:     if (enter_pulse) state_d = S_B;
                S_B:     if (enter_pulse) state_d = S_CALC;
                S_CALC:  state_d = S_SUM;
                S_SUM:   if (enter_pulse) state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cin_q, cin_d, cout_q, cout_d;
    logic [3:0]       blank_q, blank_d;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        // The mask is registered alongside the state it belongs to.
        blank_d = blank_for(state_d);
        if (clear_pulse) begin
            a_d    = '0;
            b_d    = '0;
            cin_d  = 1'b0;
            sum_d  = '0;
            cout_d = 1'b0;
        end else begin
            case (state_q)
                S_A: if (enter_pulse) a_d = Hex;
                S_B: begin
                    if (enter_pulse) begin
                        b_d   = Hex;
                        cin_d = cin_sw;
                    end
                end
                // The adder has settled on the operands loaded last cycle.
                S_CALC: begin
                    sum_d  = add_sum;
                    cout_d = add_cout;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            blank_q <= BLANK_A;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            blank_q <= blank_d;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign disp_sum  = sum_q;
    assign disp_cout = cout_q;
    assign blank     = blank_q;
    assign state_o   = state_q;

    // The digit being entered shows the switches live; otherwise the held operand.
    assign disp_a = (state_q == S_A) ? Hex : a_q;
    assign disp_b = (state_q == S_B) ? Hex : b_q;

endmodule
